edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Converts N level request lines into single-event requests via per-line rising-edge detection.
- Latches each event as pending and round-robin schedules pending events onto one shared downstream resource using a start/done handshake.
- Sits between edge-sourced event inputs (buttons, strobes, status flags) and a single-issue engine; includes a done-timeout watchdog.

Parameters:
- N, 4: number of requester lines; legal range 2..16.
- TIMEOUT, 256: max cycles spent in WAIT before abort; must be >= 2.
- ID_W, $clog2(N): derived local width of grant_id; not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0); one clock domain.
- req_in  input  N  level request lines, already synchronous to clk.
- done  input  1  resource completion pulse; sampled only in WAIT.
- ovf_clr  input  1  synchronous clear of overflow[].
- start  output  1  one-cycle pulse: resource may begin the job for grant_id.
- grant_id  output  ID_W  index of the granted requester; stable from START until the return to IDLE.
- busy  output  1  high in START and WAIT.
- pending  output  N  latched, not-yet-granted events.
- overflow  output  N  sticky: an edge arrived while that line was already pending.
- timeout  output  1  one-cycle pulse when WAIT is aborted.

Behaviour:
- Reset (rst=0, async): state=IDLE; start, busy, timeout=0; grant_id=0; pending=0; overflow=0; rr pointer=0; prev=0; armed=0.
- Edge detect:
  - prev[i] <= req_in[i] every cycle.
  - armed <= 1 on the first clock after reset release.
  - No edge is reported while armed=0, so lines high at reset release produce no event.
  - edge[i] = armed & req_in[i] & ~prev[i].
- Pending:
  - On edge[i], pending[i] is set at that same clock edge (visible in the next cycle).
  - pending[i] is cleared when i is granted.
  - Simultaneous grant-clear and new edge on the same i: pending[i] stays 1, the new event wins, and overflow is not set.
  - Edge while pending[i]=1 and not being cleared: event dropped and overflow[i] <= 1.
  - ovf_clr=1 clears all overflow bits. A set in the same cycle wins over the clear.
- FSM:
  - IDLE: if pending != 0, select the first set bit searching from ptr upward with wrap. Latch grant_id=sel, clear pending[sel], set ptr <= (sel+1) mod N, go to START. Otherwise stay in IDLE.
  - START: start=1 for exactly this cycle; timer <= 0; go to WAIT. done is ignored in this cycle.
  - WAIT:
    - If done=1, go to IDLE.
    - Else if timer == TIMEOUT-1, timeout=1 for this cycle and go to IDLE.
    - Else timer++.
    - done and the timeout condition in the same cycle: done wins, no timeout.
- Timing:
  - Minimum edge-to-start latency is 2 cycles: pending registered, then IDLE→START.
  - Minimum spacing between start pulses is 3 cycles.
- Fairness: after line i is served it has lowest priority; ptr advances only on grant.
- grant_id holds its value in IDLE until the next grant.
- Reset asserted mid-operation: everything returns to reset values immediately; in-flight grant and pending events are lost; no start or timeout pulse is produced.
- Timer width is $clog2(TIMEOUT); no wrap beyond TIMEOUT-1.

Test Plan:
- Reset with req_in=4'b0101 held high, release rst → no pending, no start. Drop line 0 low then raise it → pending=4'b0001 one cycle later, start with grant_id=0 one cycle after that.
- Edges on lines 1, 2, 3 in the same cycle with ptr=0; done returned 2 cycles after each start → grants in order 1, 2, 3. With a fresh edge on line 0 and line 1 after those grants, next grant is 0 (ptr=0 after wrap from 3), then 1.
- Line 2 pulses 0→1→0→1 while busy serving line 0 → overflow=4'b0100, pending[2]=1. ovf_clr for one cycle → overflow=0.
- Grant line 1 and never assert done with TIMEOUT=8 → timeout pulse exactly 8 cycles after entering WAIT, busy drops the next cycle, arbiter serves the next pending line.
- done asserted on the same cycle the timer reaches TIMEOUT-1 → no timeout pulse, normal return to IDLE. done asserted during the START cycle → ignored, still waits for done.
- Assert rst while in WAIT with pending=4'b1010 → all outputs, pending and overflow read 0 asynchronously. After release, a held-high req_in causes no event.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture with round-robin issue onto one start/done resource, plus a done watchdog.
// Latency: edge->start 2 cycles min, start->start 3 cycles min; one job in flight, later edges wait as pending.
module edge_event_arbiter #(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 256,
  localparam int ID_W    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_in,
  input  logic            done,
  input  logic            ovf_clr,
  output logic            start,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow,
  output logic            timeout
);

  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] ptr_nxt;
  logic            sel_vld;
  logic            armed;
  logic [N-1:0]    prev;
  logic [N-1:0]    edge_det;
  logic [N-1:0]    grant_clr;
  logic [N-1:0]    ovf_set;

  // armed stays low for the first cycle after reset so lines already high never count as edges
  assign edge_det = {N{armed}} & req_in & ~prev;

  always_comb begin
    int           idx;
    logic [N-1:0] probe;
    idx     = 0;
    probe   = '0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      probe = pending >> idx;
      if (!sel_vld && probe[0]) begin
        sel     = ID_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  assign ptr_nxt = (sel == ID_W'(N - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    grant_clr = '0;
    if (state == S_IDLE && sel_vld) grant_clr = {{(N-1){1'b0}}, 1'b1} << sel;
  end

  // a fresh edge on the line being granted re-arms it rather than counting as an overflow
  assign ovf_set = edge_det & pending & ~grant_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      armed    <= 1'b0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      prev     <= req_in;
      armed    <= 1'b1;
      pending  <= (pending & ~grant_clr) | edge_det;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      grant_id <= '0;
      ptr      <= '0;
      timer    <= '0;
    end else begin
      start   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            grant_id <= sel;
            ptr      <= ptr_nxt;
            start    <= 1'b1;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (timer == TMAX) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4, TIMEOUT=8); outputs sampled on the falling edge.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       done;
  logic       ovf_clr;
  logic       start;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_a;
  int t_b;

  edge_event_arbiter #(.N(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .done     (done),
    .ovf_clr  (ovf_clr),
    .start    (start),
    .grant_id (grant_id),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(start), 32'd1);
  endtask

  task automatic finish_job();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int n;
    rst     = 1'b0;
    req_in  = 4'b0101;
    done    = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_high_pending", 32'(pending), 0);
      chk("held_high_start", 32'(start), 0);
    end

    // line 0: low then high -> pending one cycle, start the next
    req_in = 4'b0100;
    tick();
    req_in = 4'b0101;
    tick();
    chk("l0_pending", 32'(pending), 32'b0001);
    chk("l0_no_start_yet", 32'(start), 0);
    tick();
    chk("l0_start", 32'(start), 1);
    chk("l0_grant", 32'(grant_id), 0);
    chk("l0_pending_clr", 32'(pending), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_in_start_ignored", 32'(busy), 1);
    chk("start_one_cycle", 32'(start), 0);
    tick();
    chk("still_waiting", 32'(busy), 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("l0_done_idle", 32'(busy), 0);

    // edges on 1,2,3 together -> served 1,2,3 back to back
    req_in = 4'b0000;
    tick();
    req_in = 4'b1110;
    tick();
    chk("multi_pending", 32'(pending), 32'b1110);
    wait_start("rr1");
    chk("rr1_grant", 32'(grant_id), 1);
    chk("rr1_pending", 32'(pending), 32'b1100);
    finish_job();
    wait_start("rr2");
    t_a = cyc;
    chk("rr2_grant", 32'(grant_id), 2);
    finish_job();
    wait_start("rr3");
    t_b = cyc;
    chk("rr3_grant", 32'(grant_id), 3);
    chk("start_spacing", 32'(t_b - t_a), 3);
    finish_job();

    // pointer wrapped to 0 -> line 0 before line 1
    req_in = 4'b0000;
    tick();
    req_in = 4'b0011;
    tick();
    wait_start("wrap0");
    chk("wrap0_grant", 32'(grant_id), 0);
    finish_job();
    wait_start("wrap1");
    chk("wrap1_grant", 32'(grant_id), 1);
    finish_job();

    // overflow on line 2 while line 0 is in service
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001;
    tick();
    wait_start("ovf_job");
    chk("ovf_job_grant", 32'(grant_id), 0);
    req_in = 4'b0101;
    tick();
    req_in = 4'b0001;
    tick();
    req_in = 4'b0101;
    tick();
    chk("ovf_set", 32'(overflow), 32'b0100);
    chk("ovf_pending", 32'(pending), 32'b0100);
    chk("ovf_busy", 32'(busy), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    req_in = 4'b0111;
    tick();
    chk("ovf_pending2", 32'(pending), 32'b0110);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ovf_job_done", 32'(busy), 0);

    // line 1 granted, no done -> watchdog fires 8 cycles into WAIT
    wait_start("to_job");
    chk("to_grant", 32'(grant_id), 1);
    t_a = cyc;
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("to_pulse", 32'(timeout), 1);
    chk("to_delay", 32'(cyc - t_a), 9);
    chk("to_busy_low", 32'(busy), 0);
    tick();
    chk("to_one_cycle", 32'(timeout), 0);
    chk("to_next_start", 32'(start), 1);
    chk("to_next_grant", 32'(grant_id), 2);

    // done on the last timer cycle wins over the watchdog
    for (int i = 0; i < 8; i++) tick();
    chk("edge_busy", 32'(busy), 1);
    chk("edge_no_early_to", 32'(timeout), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("edge_no_timeout", 32'(timeout), 0);
    chk("edge_idle", 32'(busy), 0);
    tick();
    chk("edge_no_late_to", 32'(timeout), 0);

    // async reset while waiting with two more lines pending
    req_in = 4'b0000;
    tick();
    req_in = 4'b0001;
    tick();
    wait_start("ar_job");
    chk("ar_grant", 32'(grant_id), 0);
    req_in = 4'b1011;
    tick();
    chk("ar_pending", 32'(pending), 32'b1010);
    chk("ar_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_pending0", 32'(pending), 0);
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_start0", 32'(start), 0);
    chk("ar_grant0", 32'(grant_id), 0);
    chk("ar_overflow0", 32'(overflow), 0);
    chk("ar_timeout0", 32'(timeout), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_held_pending", 32'(pending), 0);
      chk("ar_held_start", 32'(start), 0);
      chk("ar_held_busy", 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
